// File: rtl/alu_logic_unit_pipe_if.sv
// alu_logic_unit_pipe_if: operand/result handshake bundle for the bitwise/CPOP ALU
//   in_valid/in_ready/in_op/in_a/in_b : issue side, accept = in_valid & in_ready
//   out_valid/out_ready/out_data/out_err : writeback side, drain = out_valid & out_ready
//   master = issue/writeback logic, slave = the ALU
interface alu_logic_unit_pipe_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/alu_logic_unit_pipe.sv
// alu_logic_unit_pipe: handshaked XOR/OR/AND/ANDN/ORN/XNOR (1 cycle) and iterative CPOP ALU
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort of in-flight CPOP and pending output
//   bus   : slave side of alu_logic_unit_pipe_if (operand in, single-entry result out)
module alu_logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_logic_unit_pipe_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int AW = $clog2(WIDTH + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    logic [0:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [AW-1:0]    acc_q;
    logic [IW-1:0]    idx_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_err_q;
    logic [CHUNK-1:0] chunk;
    logic [AW-1:0]    chunk_cnt;
    logic [AW-1:0]    acc_nxt;
    logic [WIDTH-1:0] bw;
    logic             accept;
    logic             drain;
    logic             last;
    assign bus.in_ready  = (state_q == S_IDLE) & (~out_valid_q | bus.out_ready) & ~flush;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign accept  = bus.in_valid & bus.in_ready;
    assign drain   = out_valid_q & bus.out_ready;
    assign chunk   = a_q[idx_q*CHUNK +: CHUNK];
    assign acc_nxt = acc_q + chunk_cnt;
    assign last    = idx_q == IW'(N - 1);
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) chunk_cnt = chunk_cnt + AW'(chunk[i]);
    end
    always_comb
        bw = bus.in_op == 3'd0 ? bus.in_a ^ bus.in_b :
             bus.in_op == 3'd1 ? bus.in_a | bus.in_b :
             bus.in_op == 3'd2 ? bus.in_a & bus.in_b :
             bus.in_op == 3'd3 ? bus.in_a & ~bus.in_b :
             bus.in_op == 3'd4 ? bus.in_a | ~bus.in_b :
                                 ~(bus.in_a ^ bus.in_b);
    // flush outranks everything; BUSY never overlaps a pending result, so drain is only seen in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (state_q == S_BUSY) begin
            acc_q <= acc_nxt;
            idx_q <= idx_q + IW'(1);
            if (last) begin
                state_q     <= S_IDLE;
                idx_q       <= '0;
                out_data_q  <= WIDTH'(acc_nxt);
                out_err_q   <= 1'b0;
                out_valid_q <= 1'b1;
            end
        end else if (accept) begin
            if (bus.in_op == 3'd6) begin
                state_q     <= S_BUSY;
                a_q         <= bus.in_a;
                acc_q       <= '0;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_data_q  <= bus.in_op == 3'd7 ? '0 : bw;
                out_err_q   <= bus.in_op == 3'd7;
                out_valid_q <= 1'b1;
            end
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
